perf_monitor: RTL and testbench

- Synthesizable, parametrised performance monitor for the systolic-array subsystem.
- Counts request events and request-high cycles on NUM_CH memory-bus channels (e.g. a_bus, b_bus, c_bus) over an armed measurement window.
- Separately counts compute cycles between a trigger pulse (start_array) and a stop pulse (array_done).
- Results are read back through a registered select port.

---
 rtl/perf_monitor.sv | 199 +++++++++++++++++++
 tb/tb_perf_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Performance monitor for the systolic-array subsystem.
// It counts request events and request-high (busy) cycles per bus channel
// during an armed window. It also counts compute cycles from a trigger
// pulse to a stop pulse. Results are read back through a registered
// select port.
module perf_monitor #(
    parameter int  NUM_CH    = 3,
    parameter int  CNT_WIDTH = 32,
    localparam int NUM_CNT   = 2 * NUM_CH + 1,
    localparam int SEL_W     = $clog2(NUM_CNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 arm_i,
    input  logic                 trigger_i,
    input  logic                 stop_i,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic [1:0]           state_o,
    output logic                 done_o,
    output logic [NUM_CNT-1:0]   overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Saturating increment: the MSB of the result flags an increment that
    // was attempted at full scale. In that case the value holds.
    function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = {1'b1, v};
        end else begin
            r = {1'b0, v + CNT_WIDTH'(1'b1)};
        end
        return r;
    endfunction

    // Counter layout: index 0 = cycles, 1..NUM_CH = events,
    // NUM_CH+1..2*NUM_CH = busy. The overflow bits use the same layout.
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_CNT];
    logic [CNT_WIDTH:0]     inc_s [NUM_CNT];
    logic [NUM_CNT-1:0]     ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [NUM_CH-1:0]      req_q;
    logic [NUM_CH-1:0]      event_s;
    logic                   counting_s;
    logic                   clr_s;
    logic [CNT_WIDTH-1:0]   rd_data_q;
    logic [CNT_WIDTH-1:0]   rd_mux_s;

    // Precompute the saturating increment of every counter.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            inc_s[i] = sat_inc(cnt_q[i]);
        end
    end

    // Rising-edge detect on each request line against last cycle's level.
    always_comb begin
        event_s = req_i & ~req_q;
    end

    // Compute next state and next counter values. The arm edge clears all
    // counters. It never counts, because counting happens only in ARMED or COUNT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        clr_s      = 1'b0;
        counting_s = (state_q == ST_ARMED) || (state_q == ST_COUNT);

        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d = ST_ARMED;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (trigger_i) begin
                    state_d  = ST_COUNT;
                    cnt_d[0] = '0;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_COUNT: begin
                // The stop edge itself is still a counted cycle.
                cnt_d[0] = inc_s[0][CNT_WIDTH-1:0];
                ovf_d[0] = ovf_q[0] | inc_s[0][CNT_WIDTH];
                if (stop_i) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    state_d = ST_ARMED;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int k = 0; k < NUM_CH; k++) begin
            if (counting_s && event_s[k]) begin
                cnt_d[1 + k] = inc_s[1 + k][CNT_WIDTH-1:0];
                ovf_d[1 + k] = ovf_q[1 + k] | inc_s[1 + k][CNT_WIDTH];
            end else begin
                cnt_d[1 + k] = cnt_q[1 + k];
            end
            if (counting_s && req_i[k]) begin
                cnt_d[1 + NUM_CH + k] = inc_s[1 + NUM_CH + k][CNT_WIDTH-1:0];
                ovf_d[1 + NUM_CH + k] = ovf_q[1 + NUM_CH + k] | inc_s[1 + NUM_CH + k][CNT_WIDTH];
            end else begin
                cnt_d[1 + NUM_CH + k] = cnt_q[1 + NUM_CH + k];
            end
        end

        if (clr_s) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_d[i] = '0;
            end
            ovf_d = '0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Select the readback source. Out-of-range selects read as zero.
    always_comb begin
        rd_mux_s = '0;
        if (32'(rd_sel_i) < 32'(NUM_CNT)) begin
            rd_mux_s = cnt_q[rd_sel_i];
        end else begin
            rd_mux_s = '0;
        end
    end

    // Hold the FSM, counters, flags and request history. Soft clear mirrors reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q  <= '0;
            done_q <= 1'b0;
            req_q  <= '0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q  <= '0;
            done_q <= 1'b0;
            req_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            req_q   <= req_i;
        end
    end

    // Register the readback. It shows the pre-update value and keeps reading through a soft clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_mux_s;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign state_o    = state_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed self-checking bench for perf_monitor.
// It uses a default-width instance and a 4-bit instance that shares the
// same inputs. The 4-bit instance is used to check saturation.
module tb_perf_monitor;

    logic        clk;
    logic        reset;
    logic        clear_i;
    logic        arm_i;
    logic        trigger_i;
    logic        stop_i;
    logic [2:0]  req_i;
    logic [2:0]  rd_sel_i;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        done;
    logic [6:0]  ovf;
    logic [3:0]  rd_data_s;
    logic [1:0]  state_s;
    logic        done_s;
    logic [6:0]  ovf_s;

    int n_chk = 0;
    int n_err = 0;

    perf_monitor #(.NUM_CH(3), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .arm_i(arm_i),
        .trigger_i(trigger_i), .stop_i(stop_i), .req_i(req_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data), .state_o(state),
        .done_o(done), .overflow_o(ovf)
    );

    perf_monitor #(.NUM_CH(3), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .clear_i(clear_i), .arm_i(arm_i),
        .trigger_i(trigger_i), .stop_i(stop_i), .req_i(req_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_s), .state_o(state_s),
        .done_o(done_s), .overflow_o(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; clear_i = 1'b0; arm_i = 1'b0; trigger_i = 1'b0;
        stop_i = 1'b0; req_i = 3'b000; rd_sel_i = 3'd0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd0);

        // Basic window: 4 events in ARMED, 100 compute cycles.
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        chk("arm_state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            req_i = 3'b001; tick();
            req_i = 3'b000; tick();
        end
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        chk("count_state", 32'(state), 32'd2);
        for (int i = 0; i < 99; i++) tick();
        chk("done_pre", 32'(done), 32'd0);
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        chk("done_state", 32'(state), 32'd3);
        chk("done_pulse", 32'(done), 32'd1);
        tick();
        chk("done_drop", 32'(done), 32'd0);
        chk("done_hold", 32'(state), 32'd3);
        rd_sel_i = 3'd1; tick(); chk("basic_evt0", rd_data, 32'd4);
        rd_sel_i = 3'd0; tick(); chk("basic_cyc", rd_data, 32'd100);
        rd_sel_i = 3'd4; tick(); chk("basic_busy0", rd_data, 32'd4);

        // Busy count: req_i[1] held for 37 edges inside COUNT.
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        req_i = 3'b010;
        for (int i = 0; i < 37; i++) tick();
        req_i = 3'b000;
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        rd_sel_i = 3'd2; tick(); chk("busy_evt1", rd_data, 32'd1);
        rd_sel_i = 3'd5;
        chk("rd_latency", rd_data, 32'd1);
        tick(); chk("busy_busy1", rd_data, 32'd37);
        rd_sel_i = 3'd1; tick(); chk("busy_evt0_cleared", rd_data, 32'd0);

        // Boundary edges on req_i[2].
        req_i = 3'b100; arm_i = 1'b1; tick(); arm_i = 1'b0;
        req_i = 3'b000; tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        chk("stop_in_armed", 32'(state), 32'd1);
        chk("stop_in_armed_done", 32'(done), 32'd0);
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        req_i = 3'b100; stop_i = 1'b1; tick(); stop_i = 1'b0; req_i = 3'b000;
        chk("bnd_state", 32'(state), 32'd3);
        rd_sel_i = 3'd3; tick(); chk("bnd_evt2", rd_data, 32'd1);
        rd_sel_i = 3'd6; tick(); chk("bnd_busy2", rd_data, 32'd1);
        rd_sel_i = 3'd0; tick(); chk("bnd_cyc", rd_data, 32'd1);

        // Saturation on the 4-bit instance: 20 events in ARMED.
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        chk("sat_ovf_armclr", 32'(ovf_s), 32'd0);
        for (int i = 0; i < 20; i++) begin
            req_i = 3'b001; tick();
            req_i = 3'b000; tick();
        end
        rd_sel_i = 3'd1; tick();
        chk("sat_evt0_small", 32'(rd_data_s), 32'd15);
        chk("sat_evt0_wide", rd_data, 32'd20);
        rd_sel_i = 3'd4; tick();
        chk("sat_busy0_small", 32'(rd_data_s), 32'd15);
        chk("sat_ovf_small", 32'(ovf_s), 32'h12);
        chk("sat_ovf_wide", 32'(ovf), 32'd0);
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        chk("rearm_ovf_small", 32'(ovf_s), 32'd0);
        rd_sel_i = 3'd1; tick();
        chk("rearm_evt0_small", 32'(rd_data_s), 32'd0);

        // Two windows, no accumulation.
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        rd_sel_i = 3'd0; tick(); chk("win64_cyc", rd_data, 32'd64);
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        for (int i = 0; i < 127; i++) tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        tick(); chk("win128_cyc", rd_data, 32'd128);

        // Soft clear in COUNT.
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        req_i = 3'b111;
        for (int i = 0; i < 5; i++) tick();
        req_i = 3'b000; clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("clr_rd_preval", rd_data, 32'd5);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        for (int s = 0; s < 7; s++) begin
            rd_sel_i = 3'(s); tick();
            chk("clr_read_zero", rd_data, 32'd0);
        end

        // Async reset between edges in COUNT.
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        trigger_i = 1'b1; tick(); trigger_i = 1'b0;
        rd_sel_i = 3'd0; req_i = 3'b001;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_rd", rd_data, 32'd9);
        chk("pre_reset_state", 32'(state), 32'd2);
        req_i = 3'b000;
        #2 reset = 1'b1;
        #1;
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_rd", rd_data, 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        chk("areset_ovf", 32'(ovf), 32'd0);
        #1 reset = 1'b0;
        rd_sel_i = 3'd7; tick();
        chk("oor_read", rd_data, 32'd0);
        chk("post_reset_state", 32'(state), 32'd0);
        rd_sel_i = 3'd0; tick();
        chk("post_reset_cyc", rd_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
